// File: rtl/hazard_ctrl_if.sv
// Data-memory request/ready handshake between the hazard controller
// (master, drives the request) and the data memory (slave, answers ready).
interface hazard_ctrl_if;
   logic dmem_req;
   logic dmem_ready;

   modport master (output dmem_req, input dmem_ready);
   modport slave  (input dmem_req, output dmem_ready);
endinterface

// File: rtl/hazard_ctrl.sv
// Central hazard/stall controller for the 5-stage RISC-V pipeline:
// forwarding selects, per-stage stall/flush enables, a data-memory
// request/ready FSM that freezes the pipeline while an access is
// outstanding, and saturating event counters for performance debug.
module hazard_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic             RegWriteM,
   input  logic             MemAccessM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteW,
   hazard_ctrl_if.master    dmem,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] lw_stall_cnt,
   output logic [CNT_W-1:0] br_flush_cnt,
   output logic [CNT_W-1:0] mem_stall_cnt
);

   // Wait counter only needs to reach TIMEOUT; it parks there.
   localparam int WC_W = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

   // Counter slots: 0 = load-use stalls, 1 = branch flushes, 2 = memory stalls
   localparam int N_CNT = 3;

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t                       state_q, state_d;
   logic [WC_W-1:0]              wait_cnt_q, wait_cnt_d;
   logic                         mem_timeout_q, mem_timeout_d;
   logic [N_CNT-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_CNT-1:0]             cnt_inc;

   logic                         mem_stall;
   logic                         dmem_req_c;
   logic                         lw_hz;

   // Forwarding selects: the younger Memory-stage result beats Writeback.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
         ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
         ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
         ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
         ForwardBE = 2'b01;
   end

   // Load in Execute whose destination is read by the instruction in Decode.
   always_comb begin
      lw_hz = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
              ((RdE == Rs1D) || (RdE == Rs2D));
   end

   // Memory handshake FSM: next state, wait counter and sticky timeout.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      dmem_req_c    = 1'b0;
      mem_stall     = 1'b0;
      case (state_q)
         S_IDLE: begin
            dmem_req_c = MemAccessM;
            if (MemAccessM && !dmem.dmem_ready) begin
               mem_stall  = 1'b1;
               state_d    = S_WAIT;
               wait_cnt_d = '0;
            end
         end
         S_WAIT: begin
            dmem_req_c = 1'b1;
            if (dmem.dmem_ready) begin
               // Access completes; the pipeline advances this same cycle.
               state_d = S_IDLE;
            end else begin
               mem_stall = 1'b1;
               if (wait_cnt_q != WC_MAX)
                  wait_cnt_d = wait_cnt_q + 1'b1;
               // This un-ready cycle is the TIMEOUT-th one spent in WAIT.
               if (wait_cnt_q >= WC_LAST)
                  mem_timeout_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Event counters: each counts the cycles in which its output rule wins.
   always_comb begin
      cnt_inc[0] = lw_hz && !PCSrcE && !mem_stall;
      cnt_inc[1] = PCSrcE && !mem_stall;
      cnt_inc[2] = mem_stall;
      for (int i = 0; i < N_CNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}}))
            cnt_d[i] = cnt_q[i] + 1'b1;
      end
   end

   // Prioritised stall/flush enables; everything is quiet while in reset.
   always_comb begin
      StallF          = 1'b0;
      StallD          = 1'b0;
      StallE          = 1'b0;
      StallM          = 1'b0;
      FlushD          = 1'b0;
      FlushE          = 1'b0;
      FlushW          = 1'b0;
      dmem.dmem_req   = 1'b0;
      if (reset_n) begin
         dmem.dmem_req = dmem_req_c;
         if (mem_stall) begin
            // Freeze everything; branch and load-use are re-evaluated on release.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (lw_hz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // State, wait counter, timeout flag and event counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign mem_timeout   = mem_timeout_q;
   assign lw_stall_cnt  = cnt_q[0];
   assign br_flush_cnt  = cnt_q[1];
   assign mem_stall_cnt = cnt_q[2];

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard and stall controller for the 5-stage RISC-V pipeline. Produces forwarding selects, per-stage stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and runs a request/ready handshake FSM toward data memory that freezes the pipeline while an access is outstanding. Also keeps saturating stall/flush event counters for performance debug.

## Interface
- TIMEOUT, 64: WAIT cycles without ready before `mem_timeout` sets (≥2)
- CNT_W, 16: width of each event counter

- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source regs of instruction in Decode
- Rs1E, Rs2E, RdE  in  5  source/dest regs in Execute
- ResultSrcE  in  2  01 = load in Execute
- PCSrcE  in  1  taken branch/jump resolved in Execute
- RdM  in  5  dest reg in Memory
- RegWriteM  in  1  Memory-stage write enable
- MemAccessM  in  1  load or store in Memory stage
- RdW  in  5  dest reg in Writeback
- RegWriteW  in  1  Writeback-stage write enable
- dmem_ready  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  00 regfile, 01 WB result, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold PC / pipeline register
- FlushD, FlushE, FlushW  out  1  load bubble into ID/EX-side register (FlushW clears MEM/WB)
- dmem_req  out  1  data memory request
- mem_timeout  out  1  sticky: WAIT exceeded TIMEOUT
- lw_stall_cnt, br_flush_cnt, mem_stall_cnt  out  CNT_W  saturating event counters

## Operation
- Forwarding (comb): ForwardAE=10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00. ForwardBE identical with Rs2E. M has priority over W.
- lw_hz = (ResultSrcE==01) & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- FSM states IDLE, WAIT.
  - IDLE: dmem_req=MemAccessM. If MemAccessM & !dmem_ready → mem_stall=1, go WAIT. If ready same cycle → no stall, stay IDLE.
  - WAIT: dmem_req=1; mem_stall=!dmem_ready; on dmem_ready → IDLE (pipeline advances that same cycle).
  - WAIT counter: cleared on IDLE→WAIT, increments each WAIT cycle; reaching TIMEOUT sets mem_timeout (sticky until reset); FSM keeps waiting.
- Priority of outputs:
  1. mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (lw_hz/PCSrcE ignored; re-evaluated when released).
  2. PCSrcE: FlushD=FlushE=1, StallF=StallD=0 (wins over lw_hz).
  3. lw_hz: StallF=StallD=1, FlushE=1.
  4. else all 0.
- Counters (+1 per cycle, saturate at all-ones): mem_stall_cnt when mem_stall; br_flush_cnt when PCSrcE & !mem_stall; lw_stall_cnt when lw_hz & !PCSrcE & !mem_stall.

## Timing
- Forwarding, stall, flush, dmem_req combinational from inputs + state; no added latency.
- Memory with ready in request cycle: 0 stall cycles. Ready after N cycles: exactly N stall cycles.
- Load-use: exactly 1 stall cycle.
- reset_n low (async): state IDLE, WAIT counter 0, mem_timeout 0, all counters 0; while low dmem_req=0 and all Stall*=0, Flush*=0. Reset mid-WAIT abandons access; after release, dmem_req follows MemAccessM from IDLE.
- Back-to-back memory ops: WAIT→IDLE on ready; next op in M evaluated in IDLE next cycle.

## Test plan
- RegWriteM=1,RdM=5,RegWriteW=1,RdW=5,Rs1E=5,Rs2E=0 → ForwardAE=10, ForwardBE=00; RdM=0 → ForwardAE=01.
- ResultSrcE=01,RdE=7,Rs2D=7 one cycle → StallF=StallD=FlushE=1 for 1 cycle, lw_stall_cnt=1.
- MemAccessM=1, dmem_ready low 3 cycles then high → dmem_req 4 cycles, Stall*=FlushW=1 3 cycles, mem_stall_cnt=3, FSM back to IDLE.
- PCSrcE=1 with lw_hz=1 → FlushD=FlushE=1, StallF=StallD=0; br_flush_cnt+1, lw_stall_cnt unchanged.
- TIMEOUT=4, dmem_ready held low → mem_timeout rises after 4 WAIT cycles, stays 1 after ready; reset_n pulse clears it.
- reset_n low during WAIT → dmem_req=0 immediately, counters 0; after release with MemAccessM=0, no stall.
